// File: rtl/ro_pair_counter_if.sv
// Control/observation bundle between the PUF CONTROL block and one RO pair counter stage.
// The master modport is the CONTROL side; the slave modport is the counter stage.
interface ro_pair_counter_if #(
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned RESP_W = 8
);
  logic              ro_a;
  logic              ro_b;
  logic              countEN;
  logic              countReset;
  logic              refEN;
  logic              srEN;
  logic [7:0]        refcount;
  logic [CNT_W-1:0]  cnt_a;
  logic [CNT_W-1:0]  cnt_b;
  logic [RESP_W-1:0] response;
  logic              resp_valid;
  logic              tie_seen;

  modport master (
    output ro_a, ro_b, countEN, countReset, refEN, srEN,
    input  refcount, cnt_a, cnt_b, response, resp_valid, tie_seen
  );

  modport slave (
    input  ro_a, ro_b, countEN, countReset, refEN, srEN,
    output refcount, cnt_a, cnt_b, response, resp_valid, tie_seen
  );
endinterface

// File: rtl/ro_pair_counter.sv
// Ring-oscillator pair counter: synchronises and counts both oscillators, runs the reference
// window counter and shifts one comparison bit per strobe into the response word.
module ro_pair_counter #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned RESP_W  = 8,
  parameter int unsigned REF_MAX = 255
) (
  input  logic             clk,
  input  logic             rst,
  ro_pair_counter_if.slave bus
);

  localparam int unsigned      BitW   = $clog2(RESP_W + 1);
  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [7:0]       RefMax = 8'(REF_MAX);

  typedef enum logic [0:0] {StCollect, StFull} state_e;

  state_e            state_q, state_d;
  logic [2:0]        sync_a_q, sync_b_q;
  logic              edge_a, edge_b;
  logic [CNT_W-1:0]  cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic [7:0]        ref_q, ref_d;
  logic [RESP_W-1:0] resp_q, resp_d;
  logic [BitW-1:0]   bitcnt_q, bitcnt_d;
  logic              valid_q, valid_d;
  logic              tie_q, tie_d;

  // [0],[1] form the 2-FF synchroniser, [2] is the history stage for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a_q <= '0;
      sync_b_q <= '0;
    end else begin
      sync_a_q <= {sync_a_q[1:0], bus.ro_a};
      sync_b_q <= {sync_b_q[1:0], bus.ro_b};
    end
  end

  assign edge_a = sync_a_q[1] & ~sync_a_q[2];
  assign edge_b = sync_b_q[1] & ~sync_b_q[2];

  always_comb begin
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    ref_d   = ref_q;
    if (bus.countReset) begin
      cnt_a_d = '0;
      cnt_b_d = '0;
      ref_d   = '0;
    end else begin
      if (bus.countEN && edge_a && (cnt_a_q != CntMax)) cnt_a_d = cnt_a_q + 1'b1;
      if (bus.countEN && edge_b && (cnt_b_q != CntMax)) cnt_b_d = cnt_b_q + 1'b1;
      if (bus.refEN && (ref_q < RefMax))                ref_d   = ref_q + 1'b1;
    end
  end

  // Compare reads the registered counts, so a same-cycle countReset sees the pre-clear values.
  always_comb begin
    state_d  = state_q;
    resp_d   = resp_q;
    bitcnt_d = bitcnt_q;
    valid_d  = valid_q;
    tie_d    = tie_q;
    unique case (state_q)
      StCollect: begin
        if (bus.srEN) begin
          resp_d   = {resp_q[RESP_W-2:0], (cnt_a_q > cnt_b_q)};
          bitcnt_d = bitcnt_q + 1'b1;
          tie_d    = tie_q | (cnt_a_q == cnt_b_q);
          if (bitcnt_q == BitW'(RESP_W - 1)) begin
            state_d = StFull;
            valid_d = 1'b1;
          end
        end
      end
      StFull: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StCollect;
      cnt_a_q  <= '0;
      cnt_b_q  <= '0;
      ref_q    <= '0;
      resp_q   <= '0;
      bitcnt_q <= '0;
      valid_q  <= 1'b0;
      tie_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_a_q  <= cnt_a_d;
      cnt_b_q  <= cnt_b_d;
      ref_q    <= ref_d;
      resp_q   <= resp_d;
      bitcnt_q <= bitcnt_d;
      valid_q  <= valid_d;
      tie_q    <= tie_d;
    end
  end

  assign bus.refcount   = ref_q;
  assign bus.cnt_a      = cnt_a_q;
  assign bus.cnt_b      = cnt_b_q;
  assign bus.response   = resp_q;
  assign bus.resp_valid = valid_q;
  assign bus.tie_seen   = tie_q;

endmodule

// File: tb/tb_ro_pair_counter.sv
// Randomised bench for ro_pair_counter with a count/compare reference model.
// Oscillators are driven as pulse trains away from clk edges; the model counts whole pulses.
module tb_ro_pair_counter;

  logic clk;
  logic rst;

  ro_pair_counter_if #(.CNT_W(16), .RESP_W(8)) bus ();

  ro_pair_counter #(.CNT_W(16), .RESP_W(8), .REF_MAX(255)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         exp_a, exp_b, exp_ref, exp_bits;
  logic [7:0] exp_resp;
  bit         exp_valid, exp_tie;

  function automatic void model_reset();
    exp_a = 0; exp_b = 0; exp_ref = 0; exp_bits = 0;
    exp_resp = 8'h00; exp_valid = 1'b0; exp_tie = 1'b0;
  endfunction

  function automatic void model_compare();
    if (!exp_valid) begin
      exp_resp = {exp_resp[6:0], (exp_a > exp_b)};
      if (exp_a == exp_b) exp_tie = 1'b1;
      exp_bits++;
      if (exp_bits == 8) exp_valid = 1'b1;
    end
  endfunction

  function automatic void model_clear();
    exp_a = 0; exp_b = 0; exp_ref = 0;
  endfunction

  task automatic apply_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    bus.ro_a = 1'b0; bus.ro_b = 1'b0; bus.countEN = 1'b0;
    bus.countReset = 1'b0; bus.refEN = 1'b0; bus.srEN = 1'b0;
    repeat (n) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic clear_counts();
    bus.countReset = 1'b1;
    @(negedge clk);
    bus.countReset = 1'b0;
    model_clear();
  endtask

  // Runs na/nb full pulses on each oscillator, then lets the synchroniser pipeline drain.
  task automatic pulse_trains(input int na, input int nb);
    int ha, la, hb, lb;
    ha = $urandom_range(1, 3); la = $urandom_range(2, 3);
    hb = $urandom_range(1, 3); lb = $urandom_range(2, 3);
    fork
      begin
        repeat (na) begin
          bus.ro_a = 1'b1; repeat (ha) @(negedge clk);
          bus.ro_a = 1'b0; repeat (la) @(negedge clk);
        end
      end
      begin
        repeat (nb) begin
          bus.ro_b = 1'b1; repeat (hb) @(negedge clk);
          bus.ro_b = 1'b0; repeat (lb) @(negedge clk);
        end
      end
    join
    repeat (4) @(negedge clk);
    if (bus.countEN) begin
      exp_a = (exp_a + na > 65535) ? 65535 : exp_a + na;
      exp_b = (exp_b + nb > 65535) ? 65535 : exp_b + nb;
    end
  endtask

  task automatic strobe(input int hold, input bit with_clear);
    bus.srEN = 1'b1;
    bus.countReset = with_clear;
    repeat (hold) begin
      model_compare();
      if (bus.countReset) model_clear();
      @(negedge clk);
      bus.countReset = 1'b0;
    end
    bus.srEN = 1'b0;
  endtask

  task automatic test_reset();
    bus.ro_a = 1'b0; bus.ro_b = 1'b0; bus.countEN = 1'b1;
    bus.countReset = 1'b0; bus.refEN = 1'b1; bus.srEN = 1'b1;
    rst = 1'b0;
    repeat (5) @(negedge clk);
    apply_reset(3);
    checks++; if (bus.refcount !== 8'd0) begin errors++;
      $display("FAIL reset_refcount got %0d want 0", bus.refcount); end
    checks++; if (bus.cnt_a !== 16'd0 || bus.cnt_b !== 16'd0) begin errors++;
      $display("FAIL reset_cnt got %0d/%0d want 0/0", bus.cnt_a, bus.cnt_b); end
    checks++; if (bus.response !== 8'd0) begin errors++;
      $display("FAIL reset_response got %h want 00", bus.response); end
    checks++; if (bus.resp_valid !== 1'b0 || bus.tie_seen !== 1'b0) begin errors++;
      $display("FAIL reset_flags got valid=%b tie=%b want 0/0", bus.resp_valid, bus.tie_seen); end
  endtask

  task automatic test_async_periods();
    apply_reset(3);
    bus.countEN = 1'b1;
    fork
      begin #2; repeat (10) begin bus.ro_a = 1'b1; #20; bus.ro_a = 1'b0; #20; end end
      begin #2; repeat (5)  begin bus.ro_b = 1'b1; #40; bus.ro_b = 1'b0; #40; end end
    join
    @(negedge clk);
    repeat (4) @(negedge clk);
    bus.countEN = 1'b0;
    exp_a = 10; exp_b = 5;
    checks++; if (bus.cnt_a < 16'd9 || bus.cnt_a > 16'd11) begin errors++;
      $display("FAIL async_cnt_a got %0d want 10+/-1", bus.cnt_a); end
    checks++; if (bus.cnt_b < 16'd4 || bus.cnt_b > 16'd6) begin errors++;
      $display("FAIL async_cnt_b got %0d want 5+/-1", bus.cnt_b); end
    strobe(1, 1'b0);
    checks++; if (bus.response[0] !== exp_resp[0]) begin errors++;
      $display("FAIL async_bit got %b want %b", bus.response[0], exp_resp[0]); end
  endtask

  task automatic test_refcount();
    apply_reset(2);
    clear_counts();
    bus.refEN = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      exp_ref = (exp_ref < 255) ? exp_ref + 1 : 255;
      checks++; if (bus.refcount !== 8'(exp_ref)) begin errors++;
        $display("FAIL refcount_cycle%0d got %0d want %0d", k, bus.refcount, exp_ref); end
    end
    bus.countReset = 1'b1;
    @(negedge clk);
    bus.countReset = 1'b0;
    bus.refEN = 1'b0;
    model_clear();
    checks++; if (bus.refcount !== 8'd0) begin errors++;
      $display("FAIL refcount_clear got %0d want 0", bus.refcount); end
  endtask

  task automatic test_alternating();
    int n, d;
    apply_reset(2);
    for (int i = 0; i < 8; i++) begin
      clear_counts();
      bus.countEN = 1'b1;
      n = $urandom_range(3, 8);
      d = $urandom_range(1, 2);
      if (i % 2 == 0) pulse_trains(n, n - d);
      else            pulse_trains(n - d, n);
      bus.countEN = 1'b0;
      checks++; if (bus.cnt_a !== 16'(exp_a) || bus.cnt_b !== 16'(exp_b)) begin errors++;
        $display("FAIL alt_counts%0d got %0d/%0d want %0d/%0d", i, bus.cnt_a, bus.cnt_b,
                 exp_a, exp_b); end
      strobe(1, 1'b0);
      checks++; if (bus.resp_valid !== exp_valid) begin errors++;
        $display("FAIL alt_valid%0d got %b want %b", i, bus.resp_valid, exp_valid); end
    end
    checks++; if (bus.response !== 8'b1010_1010 || bus.response !== exp_resp) begin errors++;
      $display("FAIL alt_response got %b want %b", bus.response, exp_resp); end
    strobe(1, 1'b0);
    checks++; if (bus.response !== exp_resp || bus.resp_valid !== 1'b1) begin errors++;
      $display("FAIL full_ignores_sr got %b/%b want %b/1", bus.response, bus.resp_valid,
               exp_resp); end
  endtask

  task automatic test_tie();
    int n;
    apply_reset(2);
    clear_counts();
    bus.countEN = 1'b1;
    n = $urandom_range(2, 6);
    // Identical waveforms on both oscillators.
    fork
      begin
        repeat (n) begin
          bus.ro_a = 1'b1; bus.ro_b = 1'b1; repeat (2) @(negedge clk);
          bus.ro_a = 1'b0; bus.ro_b = 1'b0; repeat (2) @(negedge clk);
        end
      end
    join
    repeat (4) @(negedge clk);
    exp_a = n; exp_b = n;
    strobe(1, 1'b0);
    checks++; if (bus.response[0] !== 1'b0 || bus.tie_seen !== 1'b1) begin errors++;
      $display("FAIL tie_bit got bit=%b tie=%b want 0/1", bus.response[0], bus.tie_seen); end
    pulse_trains(3, 0);
    bus.countEN = 1'b0;
    strobe(1, 1'b0);
    checks++; if (bus.response !== exp_resp || bus.tie_seen !== exp_tie) begin errors++;
      $display("FAIL tie_sticky got %b/%b want %b/%b", bus.response, bus.tie_seen,
               exp_resp, exp_tie); end
  endtask

  task automatic test_reset_mid();
    apply_reset(2);
    for (int i = 0; i < 3; i++) begin
      bus.countEN = 1'b1;
      pulse_trains(3, 1);
      bus.countEN = 1'b0;
      strobe(1, 1'b0);
    end
    apply_reset(1);
    for (int i = 0; i < 8; i++) begin
      clear_counts();
      bus.countEN = 1'b1;
      pulse_trains($urandom_range(0, 5), $urandom_range(0, 5));
      bus.countEN = 1'b0;
      strobe(1, 1'b0);
      checks++; if (bus.resp_valid !== exp_valid || bus.response !== exp_resp) begin errors++;
        $display("FAIL mid_reset%0d got %b/%b want %b/%b", i, bus.response, bus.resp_valid,
                 exp_resp, exp_valid); end
    end
  endtask

  task automatic test_back_to_back();
    int mode;
    apply_reset(2);
    for (int i = 0; i < 14; i++) begin
      bus.countEN = ($urandom_range(0, 3) != 0);
      pulse_trains($urandom_range(0, 6), $urandom_range(0, 6));
      bus.countEN = 1'b0;
      checks++; if (bus.cnt_a !== 16'(exp_a) || bus.cnt_b !== 16'(exp_b)) begin errors++;
        $display("FAIL b2b_counts%0d got %0d/%0d want %0d/%0d", i, bus.cnt_a, bus.cnt_b,
                 exp_a, exp_b); end
      mode = $urandom_range(0, 2);
      if (mode == 0)      strobe(1, 1'b0);
      else if (mode == 1) strobe(1, 1'b1);
      else                strobe(2, 1'b0);
      checks++; if (bus.response !== exp_resp || bus.resp_valid !== exp_valid ||
                    bus.tie_seen !== exp_tie) begin errors++;
        $display("FAIL b2b_resp%0d mode%0d got %b/%b/%b want %b/%b/%b", i, mode, bus.response,
                 bus.resp_valid, bus.tie_seen, exp_resp, exp_valid, exp_tie); end
      checks++; if (bus.cnt_a !== 16'(exp_a) || bus.cnt_b !== 16'(exp_b)) begin errors++;
        $display("FAIL b2b_post%0d got %0d/%0d want %0d/%0d", i, bus.cnt_a, bus.cnt_b,
                 exp_a, exp_b); end
    end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_async_periods();
    test_refcount();
    test_alternating();
    test_tie();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
